// File: rtl/demux_1to8_32b_reg.sv
// demux_1to8_32b_reg: registered 1-to-8 valid/ready stream demultiplexer with broadcast
module demux_1to8_32b_reg #(
  parameter int SIZE = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [SIZE-1:0]   in_data,
  input  logic [2:0]        in_sel,
  input  logic              in_bcast,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [8*SIZE-1:0] out_data,
  output logic [7:0]        out_valid,
  input  logic [7:0]        out_ready
);
  logic [7:0]           free;
  logic [7:0]           load;
  logic                 xfer;
  logic [7:0]           valid_d, valid_q;
  logic [7:0][SIZE-1:0] data_d, data_q;
  // a full channel being drained this cycle can take a new word
  always_comb begin
    free     = ~valid_q | out_ready;
    in_ready = in_bcast ? &free : free[in_sel];
    xfer     = in_valid & in_ready & ~reset;
    load     = xfer ? (in_bcast ? 8'hFF : 8'b1 << in_sel) : 8'h00;
  end
  // load wins over drain so each channel can pass a word every cycle
  always_comb begin
    valid_d = load | (valid_q & ~out_ready);
    data_d  = data_q;
    for (int i = 0; i < 8; i++) data_d[i] = load[i] ? in_data : data_q[i];
  end
  // holding registers, cleared on reset
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
endmodule

// File: tb/tb_demux_1to8_32b_reg.sv
// tb_demux_1to8_32b_reg: scoreboard bench for the 1-to-8 registered demultiplexer
module tb_demux_1to8_32b_reg;
  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  in_data;
  logic [2:0]   in_sel;
  logic         in_bcast;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] out_data;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;

  int n_cmp = 0;
  int n_bad = 0;
  logic        mon_en = 1'b0;
  logic [7:0]  mv = '0;
  logic [31:0] exp_q [8][$];

  demux_1to8_32b_reg #(.SIZE(32)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] slice(input int i);
    return out_data[i*32 +: 32];
  endfunction

  // reference model: checks handshakes, pops drained words, pushes accepted words
  always @(negedge clock) begin
    if (mon_en) begin
      logic [7:0] mfree;
      logic       mrdy;
      mfree = ~mv | out_ready;
      mrdy  = in_bcast ? &mfree : mfree[in_sel];
      chk("mon_in_ready", 32'(in_ready), 32'(mrdy));
      chk("mon_out_valid", 32'(out_valid), 32'(mv));
      if (reset) begin
        for (int i = 0; i < 8; i++) exp_q[i].delete();
        mv = '0;
      end else begin
        for (int i = 0; i < 8; i++)
          if (mv[i] && out_ready[i]) begin
            if (exp_q[i].size() == 0) chk("mon_underflow", 32'(i), 32'hFFFF_FFFF);
            else chk("mon_data", slice(i), exp_q[i].pop_front());
            mv[i] = 1'b0;
          end
        if (in_valid && mrdy)
          for (int i = 0; i < 8; i++)
            if (in_bcast || in_sel == 3'(i)) begin
              exp_q[i].push_back(in_data);
              mv[i] = 1'b1;
            end
      end
    end
  end

  initial begin
    reset = 1'b1; in_data = '0; in_sel = '0; in_bcast = 1'b0; in_valid = 1'b0; out_ready = 8'hFF;
    tick(); tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(|out_data), 32'h0);
    mon_en = 1'b1;
    tick();
    // single word to channel 3
    in_data = 32'hA5A5_0003; in_sel = 3'd3; in_valid = 1'b1;
    @(negedge clock); chk("t1_ready", 32'(in_ready), 32'h1);
    tick(); in_valid = 1'b0;
    @(negedge clock); chk("t1_valid", 32'(out_valid), 32'h08); chk("t1_data", slice(3), 32'hA5A5_0003);
    tick();
    @(negedge clock); chk("t1_empty", 32'(out_valid), 32'h0);
    // back-pressure on channel 5
    out_ready = 8'hDF; in_data = 32'h11; in_sel = 3'd5; in_valid = 1'b1;
    tick(); in_data = 32'h22;
    @(negedge clock); chk("t2_stall", 32'(in_ready), 32'h0); chk("t2_hold", slice(5), 32'h11);
    tick();
    @(negedge clock); chk("t2_stall2", 32'(in_ready), 32'h0); chk("t2_hold2", slice(5), 32'h11);
    out_ready = 8'hFF;
    @(negedge clock); chk("t2_free", 32'(in_ready), 32'h1);
    tick(); in_valid = 1'b0;
    @(negedge clock); chk("t2_valid", 32'(out_valid), 32'h20); chk("t2_data", slice(5), 32'h22);
    tick();
    @(negedge clock); chk("t2_empty", 32'(out_valid), 32'h0);
    // independence: channel 2 stalled, channel 6 flows
    out_ready = 8'hFB; in_data = 32'h55; in_sel = 3'd2; in_valid = 1'b1;
    tick(); in_data = 32'h77; in_sel = 3'd6;
    @(negedge clock); chk("t3_ready", 32'(in_ready), 32'h1);
    tick(); in_valid = 1'b0;
    @(negedge clock); chk("t3_valid", 32'(out_valid), 32'h44);
    chk("t3_d6", slice(6), 32'h77); chk("t3_d2", slice(2), 32'h55);
    tick();
    @(negedge clock); chk("t3_valid2", 32'(out_valid), 32'h04); chk("t3_d2b", slice(2), 32'h55);
    // broadcast blocked by full channel 0, then released
    out_ready = 8'hFE; in_data = 32'h9; in_sel = 3'd0; in_valid = 1'b1;
    tick(); in_bcast = 1'b1; in_data = 32'hDEAD_BEEF; in_sel = 3'd4;
    @(negedge clock); chk("t4_block", 32'(in_ready), 32'h0);
    tick();
    @(negedge clock); chk("t4_noload", 32'(out_valid), 32'h01); chk("t4_d0", slice(0), 32'h9);
    out_ready = 8'hFF;
    @(negedge clock); chk("t4_ready", 32'(in_ready), 32'h1);
    tick(); in_valid = 1'b0; in_bcast = 1'b0;
    @(negedge clock); chk("t4_all", 32'(out_valid), 32'hFF);
    for (int i = 0; i < 8; i++) chk("t4_bdata", slice(i), 32'hDEAD_BEEF);
    tick();
    // streaming across all channels
    for (int i = 0; i < 8; i++) begin
      in_sel = 3'(i); in_data = 32'h100 + 32'(i); in_valid = 1'b1;
      @(negedge clock); chk("t5_ready", 32'(in_ready), 32'h1);
      if (i > 0) begin
        chk("t5_valid", 32'(out_valid), 32'(8'b1 << (i - 1)));
        chk("t5_data", slice(i - 1), 32'h100 + 32'(i - 1));
      end
      tick();
    end
    in_valid = 1'b0;
    @(negedge clock); chk("t5_valid7", 32'(out_valid), 32'h80); chk("t5_data7", slice(7), 32'h107);
    tick();
    // reset mid-operation
    out_ready = 8'hED; in_data = 32'hA1; in_sel = 3'd1; in_valid = 1'b1;
    tick(); in_data = 32'hA4; in_sel = 3'd4;
    tick(); in_valid = 1'b0;
    @(negedge clock); chk("t6_full", 32'(out_valid), 32'h12);
    out_ready = 8'hEF; reset = 1'b1; in_valid = 1'b1; in_sel = 3'd1; in_data = 32'hBAD;
    @(negedge clock); chk("t6_rdy_in_rst", 32'(in_ready), 32'h1);
    tick(); reset = 1'b0; in_valid = 1'b0; out_ready = 8'h00;
    @(negedge clock); chk("t6_valid", 32'(out_valid), 32'h0); chk("t6_data", 32'(|out_data), 32'h0);
    tick();
    @(negedge clock); chk("t6_nodeliver", 32'(out_valid), 32'h0);
    for (int i = 0; i < 8; i++) chk("q_empty", 32'(exp_q[i].size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/demux_1to8_32b_reg.md
Name: demux_1to8_32b_reg

Overview:
- Registered 1-to-8 stream demultiplexer: the distributing counterpart of the CGRA 8-to-1 operand multiplexer.
- Takes one valid/ready input stream and steers each word to one of eight output channels chosen by a per-word select field. A broadcast mode copies one word to all eight channels.
- Each output channel has a single-entry holding register, so PE fan-out paths in the CGRA fabric get registered outputs and independent back-pressure.

Parameters:
- SIZE, 32, data width in bits of the input word and of each output channel.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  SIZE  input word.
- in_sel  input  3  destination channel index 0..7; ignored when in_bcast=1.
- in_bcast  input  1  1 = deliver the word to all 8 channels.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle (combinational).
- out_data  output  8*SIZE  channel i occupies bits [i*SIZE +: SIZE].
- out_valid  output  8  bit i = channel i holding register is full.
- out_ready  input  8  bit i = consumer of channel i accepts this cycle.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high.
  - Reset clears every out_valid bit to 0 and every out_data slice to 0.
  - A word held at reset is discarded.
  - in_ready during reset reflects the pre-reset register state, but no transfer is committed on a reset cycle.
- Channel availability: free[i] = ~out_valid[i] | out_ready[i]. A full register that is being drained in the same cycle counts as free.
- in_ready:
  - When in_bcast=0: in_ready = free[in_sel].
  - When in_bcast=1: in_ready = AND of free[0..7].
  - in_ready depends only on in_sel, in_bcast, out_valid and out_ready. It never depends on in_valid.
- Input transfer: occurs when in_valid & in_ready & ~reset.
- Load vector:
  - Non-broadcast transfer: load = one-hot(in_sel).
  - Broadcast transfer: load = 8'hFF.
  - No transfer: load = 0.
- Per-channel update, priority top to bottom:
  - reset: valid <= 0, data <= 0.
  - load[i]: data <= in_data, valid <= 1. This also covers a simultaneous drain, so a word can pass every cycle.
  - out_ready[i] & out_valid[i]: valid <= 0; data holds its last value.
  - otherwise: hold.
- Latency and throughput:
  - A word accepted in cycle N is visible on its channel (out_valid=1) in cycle N+1.
  - Each channel sustains one word per cycle while its consumer keeps out_ready high.
- Ordering and independence:
  - Per-channel order equals input acceptance order.
  - Channels never block each other, except that a broadcast waits for all eight channels.
- Broadcast is all-or-nothing: no partial delivery when some channels are stalled.
- out_ready[i] asserted while out_valid[i]=0 has no effect.
- Channels not loaded keep their data; only loaded channels change.
- Holding stability: a held word's data remains stable until its channel's handshake completes.

Test Plan:
- Reset, then send in_data=32'hA5A5_0003 with in_sel=3, in_valid=1 and all out_ready=1 -> in_ready=1. The next cycle shows out_valid=8'b0000_1000 and slice 3 = 32'hA5A5_0003; out_valid returns to 0 one cycle later.
- Back-pressure: out_ready[5]=0; send 32'h11 then 32'h22 to channel 5 -> the first is accepted and the second sees in_ready=0. Slice 5 holds 32'h11. Raising out_ready[5] drains 32'h11 and accepts 32'h22 in the same cycle; 32'h22 appears the next cycle.
- Independence: out_ready[2]=0 with channel 2 full; send 32'h77 to channel 6 -> accepted immediately, out_valid[6]=1 next cycle, and channel 2 is unchanged.
- Broadcast: in_bcast=1, in_data=32'hDEAD_BEEF with out_ready[0]=0 and channel 0 full -> in_ready=0 and no channel is loaded. Raise out_ready[0] -> transfer occurs and the next cycle shows out_valid=8'hFF with all slices = 32'hDEAD_BEEF.
- Streaming: in_sel cycles through 0..7 every clock with in_valid=1, all out_ready=1, data = 32'h100+index -> in_ready stays 1 throughout. Each channel i shows 32'h100+i exactly one cycle after its acceptance.
- Reset mid-operation: channels 1 and 4 full with out_ready=0; assert reset together with in_valid=1 and in_sel=1 -> the next cycle shows out_valid=0, all out_data=0, and the word sent in the reset cycle is not delivered.
